param_count_stream: RTL and testbench
=====================================

PARAM_COUNT_STREAM -- requirements
Module: param_count_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 8, counter and data width in bits (>=2).
REQ-002 SHALL have parameter DEPTH, default 4, output FIFO entries (power of 2, >=2).
REQ-003 SHALL have parameter STEP, default 1, increment/decrement amount (1 .. 2^WIDTH-1).
REQ-004 SHALL have parameter SATURATE, default 0, 0 = wrap modulo 2^WIDTH, 1 = clamp at 0 / 2^WIDTH-1.
REQ-005 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port en  input  1  count enable, one count step per cycle while high.
REQ-008 SHALL have port down  input  1  direction, 0 = up, 1 = down.
REQ-009 SHALL have port load  input  1  synchronous load of load_val into counter.
REQ-010 SHALL have port load_val  input  WIDTH  load value.
REQ-011 SHALL have port out_ready  input  1  consumer accepts out_data this cycle.
REQ-012 SHALL have port clr_ovf  input  1  clears sticky overflow.
REQ-013 SHALL have port count  output  WIDTH  current counter register.
REQ-014 SHALL have port out_data  output  WIDTH  FIFO head value.
REQ-015 SHALL have port dr  output  1  data ready (FIFO non-empty).
REQ-016 SHALL have port level  output  $clog2(DEPTH)+1  FIFO occupancy.
REQ-017 SHALL have port full  output  1  level == DEPTH.
REQ-018 SHALL have port overflow  output  1  sticky, a push was dropped.

Function
REQ-019 SHALL give load priority over en: load=1 -> count <= load_val, no FIFO push, regardless of en.
REQ-020 SHALL, when en=1 and load=0, set count <= count+STEP (down=0) or count-STEP (down=1), and push the new count value into the FIFO on the same edge.
REQ-021 SHALL, with SATURATE=0, wrap the result modulo 2^WIDTH.
REQ-022 SHALL, with SATURATE=1, clamp up-steps exceeding 2^WIDTH-1 to 2^WIDTH-1 and down-steps below 0 to 0; the clamped value is still pushed.
REQ-023 SHALL keep count unchanged when en=0 and load=0.
REQ-024 SHALL be first-word-fall-through: the value pushed at edge N appears on out_data with dr=1 after edge N (1-cycle latency), when the FIFO was empty.
REQ-025 SHALL pop the head on a rising edge when dr=1 and out_ready=1; out_ready with dr=0 has no effect.
REQ-026 SHALL drive out_data = 0 whenever dr=0.
REQ-027 SHALL, on push with pop in the same cycle, keep level unchanged, including when full; no overflow.
REQ-028 SHALL, on push while full with no pop, drop the value, keep FIFO contents, set overflow=1; count still updates.
REQ-029 SHALL hold overflow until a cycle with clr_ovf=1; clr_ovf and a new drop in the same cycle leaves overflow=1.
REQ-030 SHALL derive FIFO pointers modulo DEPTH; level never exceeds DEPTH nor underflows.
REQ-031 SHALL change full and dr only on clock edges (registered-state derived), never combinationally from inputs.

Reset
REQ-032 SHALL, on rst low, immediately set count=0, level=0, dr=0, full=0, overflow=0, out_data=0, pointers=0, independent of clk.
REQ-033 SHALL discard FIFO contents and any in-progress push on reset mid-operation; first push after release occurs on the first rising edge with rst high and en=1.

Verification (WIDTH=8, DEPTH=4, STEP=1 unless noted)
REQ-034 SHALL cover: en=1 for 3 cycles, out_ready=0 -> count=3, level=3, dr=1, out_data=0x01; then out_ready=1 for 3 cycles -> 0x01, 0x02, 0x03 accepted, dr=0, out_data=0.
REQ-035 SHALL cover: en=1 for 6 cycles, out_ready=0 -> count=6, level=4, full=1, contents 0x01..0x04, overflow=1; clr_ovf pulse -> overflow=0.
REQ-036 SHALL cover: load 0xFE, then en=1 for 3 cycles, drain -> SATURATE=0 yields 0xFF, 0x00, 0x01; SATURATE=1 yields 0xFF, 0xFF, 0xFF.
REQ-037 SHALL cover: load 0x02, down=1, en=1 for 3 cycles (SATURATE=0) -> 0x01, 0x00, 0xFF; with STEP=3 from load 0x10 up -> 0x13, 0x16, 0x19.
REQ-038 SHALL cover: FIFO full, en=1 and out_ready=1 for 4 cycles -> level stays 4, overflow stays 0, head advances one entry per cycle.
REQ-039 SHALL cover: rst driven low between clock edges with level=3 -> count, level, dr, overflow, out_data all 0 before next edge; load asserted with en same cycle -> count=load_val, level unchanged.

Source files
------------

// File: rtl/param_count_stream.sv
// Up/down counter (wrapping or saturating) whose every counted value is pushed
// into a small first-word-fall-through output FIFO with a sticky drop flag.
module param_count_stream #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int STEP     = 1,
  parameter int SATURATE = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     down,
  input  logic                     load,
  input  logic [WIDTH-1:0]         load_val,
  input  logic                     out_ready,
  input  logic                     clr_ovf,
  output logic [WIDTH-1:0]         count,
  output logic [WIDTH-1:0]         out_data,
  output logic                     dr,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [WIDTH:0] STEP_EXT = (WIDTH+1)'(STEP);

  logic [WIDTH-1:0] count_reg, count_next;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [LVL_W-1:0] level_reg, level_next;
  logic             ovf_reg, ovf_next;
  logic [WIDTH-1:0] mem_reg [DEPTH];

  logic [WIDTH:0]   sum_up, diff_dn;
  logic [WIDTH-1:0] step_val;
  logic             fifo_empty, fifo_full;
  logic             pop, push_req, push, drop;
  logic [DEPTH-1:0] wr_en;

  // One extra bit on the arithmetic exposes carry (up) or borrow (down).
  always_comb begin
    sum_up  = {1'b0, count_reg} + STEP_EXT;
    diff_dn = {1'b0, count_reg} - STEP_EXT;
    if (down) begin
      if (SATURATE != 0 && diff_dn[WIDTH]) step_val = '0;
      else                                 step_val = diff_dn[WIDTH-1:0];
    end else begin
      if (SATURATE != 0 && sum_up[WIDTH])  step_val = '1;
      else                                 step_val = sum_up[WIDTH-1:0];
    end
  end

  always_comb begin
    fifo_empty = (level_reg == '0);
    fifo_full  = (level_reg == LVL_W'(DEPTH));
    pop        = !fifo_empty && out_ready;
    push_req   = en && !load;
    // A simultaneous pop frees a slot, so a full FIFO can still accept.
    push       = push_req && (!fifo_full || pop);
    drop       = push_req && fifo_full && !pop;

    count_next = count_reg;
    if (load)    count_next = load_val;
    else if (en) count_next = step_val;

    wr_ptr_next = push ? wr_ptr_reg + PTR_W'(1) : wr_ptr_reg;
    rd_ptr_next = pop  ? rd_ptr_reg + PTR_W'(1) : rd_ptr_reg;

    level_next = level_reg;
    case ({push, pop})
      2'b10:   level_next = level_reg + LVL_W'(1);
      2'b01:   level_next = level_reg - LVL_W'(1);
      default: level_next = level_reg;
    endcase

    ovf_next = ovf_reg;
    if (drop)         ovf_next = 1'b1;
    else if (clr_ovf) ovf_next = 1'b0;
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
    assign wr_en[gi] = push && (wr_ptr_reg == PTR_W'(gi));
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_en[i]) mem_reg[i] <= step_val;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg  <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      count_reg  <= count_next;
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      level_reg  <= level_next;
      ovf_reg    <= ovf_next;
    end
  end

  // Status is a pure function of registered state; out_data is masked when empty.
  assign count    = count_reg;
  assign level    = level_reg;
  assign dr       = !fifo_empty;
  assign full     = fifo_full;
  assign overflow = ovf_reg;
  assign out_data = fifo_empty ? '0 : mem_reg[rd_ptr_reg];

endmodule

// File: tb/tb_param_count_stream.sv
// Randomized + directed bench for param_count_stream: three variants (wrap, saturate,
// STEP=3) share stimulus; a queue model predicts state and a scoreboard checks output data.
`timescale 1ns/1ps
module tb_param_count_stream;
  localparam int N = 3;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0, down = 1'b0, load = 1'b0, out_ready = 1'b0, clr_ovf = 1'b0;
  logic [7:0] load_val = 8'h00;

  logic [7:0] d_count [N];
  logic [7:0] d_out   [N];
  logic       d_dr    [N];
  logic       d_full  [N];
  logic       d_ovf   [N];
  logic [2:0] d_level [N];

  int checks = 0;
  int errors = 0;

  int         steps [N] = '{1, 1, 3};
  int         sats  [N] = '{0, 1, 0};
  int         m_count [N];
  bit         m_ovf   [N];
  logic [7:0] m_q     [N][$];
  logic [7:0] exp_q   [N][$];
  logic [7:0] sb_exp;

  always #5 clk = ~clk;

  param_count_stream #(.WIDTH(8), .DEPTH(DEPTH), .STEP(1), .SATURATE(0)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .down(down), .load(load), .load_val(load_val),
    .out_ready(out_ready), .clr_ovf(clr_ovf), .count(d_count[0]), .out_data(d_out[0]),
    .dr(d_dr[0]), .level(d_level[0]), .full(d_full[0]), .overflow(d_ovf[0]));

  param_count_stream #(.WIDTH(8), .DEPTH(DEPTH), .STEP(1), .SATURATE(1)) u_sat (
    .clk(clk), .rst(rst), .en(en), .down(down), .load(load), .load_val(load_val),
    .out_ready(out_ready), .clr_ovf(clr_ovf), .count(d_count[1]), .out_data(d_out[1]),
    .dr(d_dr[1]), .level(d_level[1]), .full(d_full[1]), .overflow(d_ovf[1]));

  param_count_stream #(.WIDTH(8), .DEPTH(DEPTH), .STEP(3), .SATURATE(0)) u_step3 (
    .clk(clk), .rst(rst), .en(en), .down(down), .load(load), .load_val(load_val),
    .out_ready(out_ready), .clr_ovf(clr_ovf), .count(d_count[2]), .out_data(d_out[2]),
    .dr(d_dr[2]), .level(d_level[2]), .full(d_full[2]), .overflow(d_ovf[2]));

  task automatic chk(input string name, input int k, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s dut%0d got 0x%0h expected 0x%0h", name, k, act, exp);
    end
  endtask

  // Counting rule in plain integer arithmetic.
  function automatic int next_val(input int c, input bit dn, input int s, input int sat);
    int v;
    v = dn ? c - s : c + s;
    if (sat != 0) begin
      if (v < 0)   v = 0;
      if (v > 255) v = 255;
    end
    return ((v % 256) + 256) % 256;
  endfunction

  // Predicts the effect of the current inputs at the coming rising edge.
  task automatic model_step();
    for (int k = 0; k < N; k++) begin
      bit pop;
      bit dropped;
      int nc;
      pop = (m_q[k].size() > 0) && out_ready;
      dropped = 1'b0;
      if (pop) void'(m_q[k].pop_front());
      if (load) begin
        m_count[k] = int'(load_val);
      end else if (en) begin
        nc = next_val(m_count[k], down, steps[k], sats[k]);
        m_count[k] = nc;
        if (m_q[k].size() < DEPTH) begin
          m_q[k].push_back(8'(nc));
          exp_q[k].push_back(8'(nc));
        end else begin
          dropped = 1'b1;
        end
      end
      if (dropped)      m_ovf[k] = 1'b1;
      else if (clr_ovf) m_ovf[k] = 1'b0;
    end
  endtask

  task automatic check_state();
    for (int k = 0; k < N; k++) begin
      chk("count",    k, int'(d_count[k]), m_count[k]);
      chk("level",    k, int'(d_level[k]), m_q[k].size());
      chk("dr",       k, int'(d_dr[k]),    (m_q[k].size() > 0) ? 1 : 0);
      chk("full",     k, int'(d_full[k]),  (m_q[k].size() == DEPTH) ? 1 : 0);
      chk("overflow", k, int'(d_ovf[k]),   int'(m_ovf[k]));
    end
  endtask

  task automatic cyc(input bit e, input bit d, input bit l, input logic [7:0] lv,
                     input bit r, input bit c);
    @(posedge clk); #2;
    check_state();
    en = e; down = d; load = l; load_val = lv; out_ready = r; clr_ovf = c;
    model_step();
  endtask

  task automatic reset_checks(input string tag);
    for (int k = 0; k < N; k++) begin
      chk({tag, "_count"},    k, int'(d_count[k]), 0);
      chk({tag, "_level"},    k, int'(d_level[k]), 0);
      chk({tag, "_dr"},       k, int'(d_dr[k]),    0);
      chk({tag, "_full"},     k, int'(d_full[k]),  0);
      chk({tag, "_overflow"}, k, int'(d_ovf[k]),   0);
      chk({tag, "_out_data"}, k, int'(d_out[k]),   0);
      m_count[k] = 0;
      m_ovf[k] = 1'b0;
      m_q[k].delete();
      exp_q[k].delete();
    end
  endtask

  // Asserts reset between edges and checks it took effect before the next edge.
  task automatic mid_reset();
    @(posedge clk); #3;
    rst = 1'b0;
    en = 1'b0; down = 1'b0; load = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
    #1;
    reset_checks("rst");
    @(posedge clk); #2;
    rst = 1'b1;
  endtask

  // Scoreboard monitor: a transfer happens at the next edge when dr && out_ready.
  always @(negedge clk) begin
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        if (d_dr[k] && out_ready) begin
          if (exp_q[k].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow dut%0d got 0x%02h expected no data", k, d_out[k]);
          end else begin
            sb_exp = exp_q[k].pop_front();
            chk("out_data", k, int'(d_out[k]), int'(sb_exp));
            $display("accept dut%0d data 0x%02h", k, d_out[k]);
          end
        end else if (!d_dr[k]) begin
          chk("idle_out_data", k, int'(d_out[k]), 0);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    #1 rst = 1'b0;
    #1 reset_checks("por");
    @(posedge clk); #2 rst = 1'b1;

    // Fill three, then drain three.
    repeat (3) cyc(1, 0, 0, 8'h00, 0, 0);
    repeat (3) cyc(0, 0, 0, 8'h00, 1, 0);
    repeat (2) cyc(0, 0, 0, 8'h00, 0, 0);

    // Overfill for drops, then clear the sticky flag.
    mid_reset();
    repeat (6) cyc(1, 0, 0, 8'h00, 0, 0);
    cyc(0, 0, 0, 8'h00, 0, 0);
    cyc(0, 0, 0, 8'h00, 0, 1);
    cyc(0, 0, 0, 8'h00, 0, 0);

    // Wrap / saturate at the top.
    mid_reset();
    cyc(0, 0, 1, 8'hFE, 0, 0);
    repeat (3) cyc(1, 0, 0, 8'h00, 0, 0);
    repeat (4) cyc(0, 0, 0, 8'h00, 1, 0);

    // Count down through zero, and step up from 0x10.
    cyc(0, 0, 1, 8'h02, 0, 0);
    repeat (3) cyc(1, 1, 0, 8'h00, 0, 0);
    repeat (4) cyc(0, 0, 0, 8'h00, 1, 0);
    cyc(0, 0, 1, 8'h10, 0, 0);
    repeat (3) cyc(1, 0, 0, 8'h00, 0, 0);
    repeat (4) cyc(0, 0, 0, 8'h00, 1, 0);

    // Simultaneous push and pop while full.
    mid_reset();
    repeat (4) cyc(1, 0, 0, 8'h00, 0, 0);
    repeat (4) cyc(1, 0, 0, 8'h00, 1, 0);
    cyc(0, 0, 0, 8'h00, 0, 0);
    repeat (5) cyc(0, 0, 0, 8'h00, 1, 0);

    // Reset with data queued, then load wins over en.
    repeat (3) cyc(1, 0, 0, 8'h00, 0, 0);
    mid_reset();
    cyc(1, 0, 1, 8'h55, 0, 0);
    repeat (2) cyc(0, 0, 0, 8'h00, 0, 0);

    // Random traffic.
    repeat (300) begin
      if ($urandom_range(0, 99) < 2)
        mid_reset();
      else
        cyc($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0,
            8'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0);
    end

    repeat (6) cyc(0, 0, 0, 8'h00, 1, 0);
    cyc(0, 0, 0, 8'h00, 0, 0);
    for (int k = 0; k < N; k++) chk("sb_leftover", k, exp_q[k].size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
